// File: rtl/fruit_launch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fruit_launch_scheduler
// Description : Frame-paced fruit spawner with slot tracking, randomised
//               descriptor decode and valid/ready launch handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module fruit_launch_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int X_LEFT_BASE    = 256,
    parameter int X_RIGHT_BASE   = 350,
    parameter int Y_VEL0         = 12,
    parameter int Y_VEL1         = 10,
    parameter int Y_VEL2         = 14,
    parameter int Y_VEL3         = 12,
    parameter int SPAWN_INTERVAL = 30,
    localparam int SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enable_in,
    input  logic                 frame_tick_in,
    input  logic [15:0]          random_in,
    input  logic [NUM_SLOTS-1:0] slot_free_in,
    input  logic                 launch_ready_in,
    output logic                 launch_valid_out,
    output logic [SLOT_W-1:0]    launch_slot_out,
    output logic [10:0]          x_start_out,
    output logic [2:0]           x_vel_out,
    output logic [4:0]           y_vel_out,
    output logic                 x_direction_neg_out,
    output logic [NUM_SLOTS-1:0] slots_busy_out,
    output logic [15:0]          spawn_count_out
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]           r_state;
    logic [12:0]          r_cooldown;
    logic [3:0]           r_jitter;
    logic [NUM_SLOTS-1:0] r_busy;
    logic [NUM_SLOTS-1:0] r_held;
    logic                 r_valid;
    logic [SLOT_W-1:0]    r_slot;
    logic [10:0]          r_x_start;
    logic [2:0]           r_x_vel;
    logic [4:0]           r_y_vel;
    logic                 r_dir;
    logic [15:0]          r_count;

    logic [NUM_SLOTS-1:0] w_free_mask;
    logic [NUM_SLOTS-1:0] w_busy_after;
    logic [NUM_SLOTS-1:0] w_avail;
    logic [NUM_SLOTS-1:0] w_onehot;
    logic [NUM_SLOTS-1:0] w_busy_next;
    logic [SLOT_W-1:0]    w_sel;
    logic                 w_tick_ok;
    logic                 w_spawn;
    logic [10:0]          w_offset;
    logic [10:0]          w_x_start;
    logic [4:0]           w_y_vel;

    // The slot being presented cannot be released until its launch is taken.
    assign w_free_mask  = slot_free_in & r_busy & ~((r_state == ST_PRESENT) ? r_held : '0);
    assign w_busy_after = r_busy & ~w_free_mask;
    assign w_avail      = ~w_busy_after;
    assign w_onehot     = w_avail & ((~w_avail) + NUM_SLOTS'(1));

    assign w_tick_ok = (r_state == ST_IDLE) && frame_tick_in && enable_in;
    assign w_spawn   = w_tick_ok && (r_cooldown == 13'd0) && (|w_avail);

    assign w_busy_next = w_busy_after | (w_spawn ? w_onehot : '0);

    assign w_offset  = {4'd0, random_in[11:5]};
    assign w_x_start = random_in[0] ? (11'(X_RIGHT_BASE) + w_offset)
                                    : (11'(X_LEFT_BASE) - w_offset);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_onehot[i]) begin
                w_sel = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        case (random_in[4:3])
            2'b00:   w_y_vel = 5'(Y_VEL0);
            2'b01:   w_y_vel = 5'(Y_VEL1);
            2'b10:   w_y_vel = 5'(Y_VEL2);
            default: w_y_vel = 5'(Y_VEL3);
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_cooldown <= '0;
            r_jitter   <= '0;
            r_busy     <= '0;
            r_held     <= '0;
            r_valid    <= 1'b0;
            r_slot     <= '0;
            r_x_start  <= '0;
            r_x_vel    <= '0;
            r_y_vel    <= '0;
            r_dir      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_busy <= w_busy_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick_ok && (r_cooldown != 13'd0)) begin
                        r_cooldown <= r_cooldown - 13'd1;
                    end
                    if (w_spawn) begin
                        r_state   <= ST_PRESENT;
                        r_valid   <= 1'b1;
                        r_slot    <= w_sel;
                        r_held    <= w_onehot;
                        r_dir     <= random_in[0];
                        r_x_vel   <= {1'b0, random_in[2:1]} + 3'd1;
                        r_y_vel   <= w_y_vel;
                        r_x_start <= w_x_start;
                        r_jitter  <= random_in[15:12];
                    end
                end
                ST_PRESENT: begin
                    if (launch_ready_in) begin
                        r_state    <= ST_IDLE;
                        r_valid    <= 1'b0;
                        r_count    <= r_count + 16'd1;
                        r_cooldown <= 13'(SPAWN_INTERVAL) + {9'd0, r_jitter};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign launch_valid_out    = r_valid;
    assign launch_slot_out     = r_slot;
    assign x_start_out         = r_x_start;
    assign x_vel_out           = r_x_vel;
    assign y_vel_out           = r_y_vel;
    assign x_direction_neg_out = r_dir;
    assign slots_busy_out      = r_busy;
    assign spawn_count_out     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fruit_launch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fruit_launch_scheduler
// Description : Directed vector bench for fruit_launch_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fruit_launch_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic        frame_tick_in;
    logic [15:0] random_in;
    logic [3:0]  slot_free_in;
    logic        launch_ready_in;
    logic        launch_valid_out;
    logic [1:0]  launch_slot_out;
    logic [10:0] x_start_out;
    logic [2:0]  x_vel_out;
    logic [4:0]  y_vel_out;
    logic        x_direction_neg_out;
    logic [3:0]  slots_busy_out;
    logic [15:0] spawn_count_out;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_in = ~clk_in;

    fruit_launch_scheduler dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .enable_in           (enable_in),
        .frame_tick_in       (frame_tick_in),
        .random_in           (random_in),
        .slot_free_in        (slot_free_in),
        .launch_ready_in     (launch_ready_in),
        .launch_valid_out    (launch_valid_out),
        .launch_slot_out     (launch_slot_out),
        .x_start_out         (x_start_out),
        .x_vel_out           (x_vel_out),
        .y_vel_out           (y_vel_out),
        .x_direction_neg_out (x_direction_neg_out),
        .slots_busy_out      (slots_busy_out),
        .spawn_count_out     (spawn_count_out)
    );

    typedef struct {
        logic [15:0] rnd;
        int          wait_n;
        logic [1:0]  slot;
        logic [10:0] xs;
        logic [2:0]  xv;
        logic [4:0]  yv;
        logic        dir;
        logic [3:0]  busy;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change just after the falling edge; outputs are read at the next one.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Enabled ticks that must not spawn, each preceded by a disabled tick
    // carrying a stray ready to show neither has an effect in IDLE.
    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            enable_in = 1'b0; frame_tick_in = 1'b1; launch_ready_in = 1'b1;
            step();
            chk("disabled_tick", {31'd0, launch_valid_out}, 32'd0);
            enable_in = 1'b1; launch_ready_in = 1'b0;
            step();
            frame_tick_in = 1'b0;
            chk("cooldown_tick", {31'd0, launch_valid_out}, 32'd0);
        end
    endtask

    task automatic accept(input logic [15:0] exp_count);
        launch_ready_in = 1'b1;
        step();
        launch_ready_in = 1'b0;
        chk("accept_valid", {31'd0, launch_valid_out}, 32'd0);
        chk("accept_count", {16'd0, spawn_count_out}, {16'd0, exp_count});
    endtask

    initial begin
        logic [31:0] exp_desc;

        vecs[0] = '{16'h0000,  0, 2'd0, 11'd256, 3'd1, 5'd12, 1'b0, 4'b0001};
        vecs[1] = '{16'h0FFF, 30, 2'd1, 11'd477, 3'd4, 5'd12, 1'b1, 4'b0011};
        vecs[2] = '{16'h3009, 30, 2'd2, 11'd350, 3'd1, 5'd10, 1'b1, 4'b0111};
        vecs[3] = '{16'h5A52, 33, 2'd3, 11'd174, 3'd2, 5'd14, 1'b0, 4'b1111};

        rst_in = 1'b1; enable_in = 1'b0; frame_tick_in = 1'b0;
        random_in = 16'h0; slot_free_in = 4'b0; launch_ready_in = 1'b0;
        @(negedge clk_in);
        step();
        step();
        rst_in = 1'b0;
        chk("reset_valid", {31'd0, launch_valid_out}, 32'd0);
        chk("reset_busy",  {28'd0, slots_busy_out}, 32'd0);
        chk("reset_count", {16'd0, spawn_count_out}, 32'd0);
        chk("reset_xstart", {21'd0, x_start_out}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            idle_ticks(vecs[v].wait_n);
            random_in = vecs[v].rnd; enable_in = 1'b1; frame_tick_in = 1'b1;
            step();
            frame_tick_in = 1'b0;
            exp_desc = {9'd0, 1'b1, vecs[v].slot, vecs[v].xs, vecs[v].xv, vecs[v].yv, vecs[v].dir};
            chk("spawn_desc", {9'd0, launch_valid_out, launch_slot_out, x_start_out,
                               x_vel_out, y_vel_out, x_direction_neg_out}, exp_desc);
            chk("spawn_busy", {28'd0, slots_busy_out}, {28'd0, vecs[v].busy});
            for (int s = 0; s < 5; s++) begin
                random_in = 16'($urandom); frame_tick_in = s[0]; enable_in = s[1];
                step();
                chk("stall_desc", {9'd0, launch_valid_out, launch_slot_out, x_start_out,
                                   x_vel_out, y_vel_out, x_direction_neg_out}, exp_desc);
            end
            frame_tick_in = 1'b0; enable_in = 1'b1;
            accept(16'(v + 1));
        end

        // Every slot taken: ticks after the cooldown must not spawn.
        idle_ticks(35);
        for (int k = 0; k < 2; k++) begin
            frame_tick_in = 1'b1; random_in = 16'h0000;
            step();
            frame_tick_in = 1'b0;
            chk("full_no_spawn", {31'd0, launch_valid_out}, 32'd0);
            chk("full_busy", {28'd0, slots_busy_out}, 32'hF);
        end
        slot_free_in = 4'b0100;
        step();
        slot_free_in = 4'b0000;
        chk("free_slot2", {28'd0, slots_busy_out}, 32'hB);
        frame_tick_in = 1'b1;
        step();
        frame_tick_in = 1'b0;
        chk("reuse_slot2", {20'd0, launch_valid_out, launch_slot_out, x_start_out},
            {20'd0, 1'b1, 2'd2, 11'd256});
        chk("reuse_busy", {28'd0, slots_busy_out}, 32'hF);
        accept(16'd5);

        // Slot freed on the same cycle as the qualifying tick is selectable.
        idle_ticks(30);
        random_in = 16'h0001; frame_tick_in = 1'b1; slot_free_in = 4'b0010;
        step();
        frame_tick_in = 1'b0; slot_free_in = 4'b0000;
        chk("same_cycle_free", {20'd0, launch_valid_out, launch_slot_out, x_start_out},
            {20'd0, 1'b1, 2'd1, 11'd350});
        chk("same_cycle_busy", {28'd0, slots_busy_out}, 32'hF);

        slot_free_in = 4'b0011;
        step();
        slot_free_in = 4'b0000;
        chk("held_slot_free", {28'd0, slots_busy_out}, 32'hE);
        chk("held_still_valid", {29'd0, launch_valid_out, launch_slot_out}, 32'h5);

        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("midreset_valid", {31'd0, launch_valid_out}, 32'd0);
        chk("midreset_busy",  {28'd0, slots_busy_out}, 32'd0);
        chk("midreset_count", {16'd0, spawn_count_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
